// File: rtl/cpu_board_ctrl_pkg.sv
// cpu_board_ctrl_pkg: FSM states, cathode table and hex-to-7-segment decoder
package cpu_board_ctrl_pkg;
  typedef enum logic [1:0] {HALT = 2'd0, RUN = 2'd1, STEP = 2'd2} state_t;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [127:0] HEX_TAB = {8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
                                      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
  function automatic logic [7:0] hex7(input logic [3:0] n);
    return 8'(HEX_TAB >> {n, 3'b000});
  endfunction
endpackage

// File: rtl/cpu_board_ctrl_debounce.sv
// btn_debounce: 2-FF synchroniser, consecutive-mismatch debouncer and rising-edge pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  logic s1, s2, done;
  logic [CW-1:0] cnt;
  assign done = (s2 != level) && (cnt == CW'(DEBOUNCE_CYC - 1));
  always_ff @(posedge clk)
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      cnt <= (s2 != level && !done) ? cnt + 1'b1 : '0;
      level <= done ? s2 : level;
      pulse <= done && s2;
    end
endmodule

// File: rtl/cpu_board_ctrl.sv
// cpu_board_ctrl: button-driven HALT/RUN/STEP clock enable, cycle counter and 7-segment scan
module cpu_board_ctrl
  import cpu_board_ctrl_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int NUM_SRC = 4,
  parameter int SEL_W = 3,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int REFRESH_DIV = 50000,
  localparam int DATA_W = 4 * DIGITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      btn_run,
  input  logic                      btn_step,
  input  logic [SEL_W-1:0]          sw_sel,
  input  logic [NUM_SRC*DATA_W-1:0] disp_data,
  output logic                      cpu_ce,
  output logic                      halted,
  output logic [31:0]               ce_count,
  output logic [DIGITS-1:0]         seg_an,
  output logic [7:0]                seg_cat
);
  localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  state_t state, state_n;
  logic run_p, step_p, ref_tc, dig_tc, unused_run_lvl, unused_step_lvl;
  logic [RW-1:0] ref_cnt;
  logic [DW-1:0] dig;
  logic [DATA_W-1:0] word, sel_word;
  logic [3:0] nib;
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_run (
    .clk(clk), .rst(rst), .raw(btn_run), .level(unused_run_lvl), .pulse(run_p)
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_step (
    .clk(clk), .rst(rst), .raw(btn_step), .level(unused_step_lvl), .pulse(step_p)
  );
  always_ff @(posedge clk) state <= rst ? HALT : state_n;
  // run wins over step in HALT; STEP always lasts exactly one cycle
  always_comb begin
    state_n = state == RUN  ? (run_p ? HALT : RUN) :
              state == HALT ? (run_p ? RUN : step_p ? STEP : HALT) : HALT;
  end
  assign cpu_ce = state == RUN || state == STEP;
  assign halted = state == HALT;
  assign ref_tc = ref_cnt == RW'(REFRESH_DIV - 1);
  assign dig_tc = dig == DW'(DIGITS - 1);
  always_comb begin
    sel_word = DATA_W'(ce_count);
    for (int k = 0; k < NUM_SRC; k++)
      if (sw_sel == SEL_W'(k)) sel_word = disp_data[k*DATA_W +: DATA_W];
  end
  assign nib = 4'(word >> {dig, 2'b00});
  // the word is only reloaded on the digit wrap so one scan never mixes two words
  always_ff @(posedge clk)
    if (rst) begin
      ce_count <= '0;
      ref_cnt <= '0;
      dig <= '0;
      word <= '0;
      seg_an <= '1;
      seg_cat <= SEG_OFF;
    end else begin
      if (cpu_ce) ce_count <= ce_count + 32'd1;
      ref_cnt <= ref_tc ? '0 : ref_cnt + 1'b1;
      if (ref_tc) dig <= dig_tc ? '0 : dig + 1'b1;
      if (ref_tc && dig_tc) word <= sel_word;
      seg_an <= ~(DIGITS'(1) << dig);
      seg_cat <= hex7(nib) & {~(dig == '0 && halted), 7'h7F};
    end
endmodule

// File: tb/tb_cpu_board_ctrl.sv
// tb_cpu_board_ctrl: vector table, hand sequences and randomized run against a behavioural model
module tb_cpu_board_ctrl;
  localparam int DG = 8, NS = 4, SW = 3, DEB = 4, RD = 2;
  logic clk = 1'b0, rst = 1'b1, btn_run = 1'b0, btn_step = 1'b0;
  logic [SW-1:0] sw_sel = '0;
  logic [NS*32-1:0] disp_data = '0;
  logic cpu_ce, halted;
  logic [31:0] ce_count;
  logic [DG-1:0] seg_an;
  logic [7:0] seg_cat;
  int tests = 0, fails = 0, cyc = 0;

  cpu_board_ctrl #(.DIGITS(DG), .NUM_SRC(NS), .SEL_W(SW), .DEBOUNCE_CYC(DEB), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_step(btn_step), .sw_sel(sw_sel),
    .disp_data(disp_data), .cpu_ce(cpu_ce), .halted(halted), .ce_count(ce_count),
    .seg_an(seg_an), .seg_cat(seg_cat)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // behavioural model: ms 0=HALT 1=RUN 2=STEP, n = clock edges since reset
  int ms = 0, n = 0;
  logic [31:0] mc = '0, mw = '0;
  logic [7:0] man = '1, mcat = 8'hFF;
  logic [1:0] dl [2];
  logic [DEB-1:0] sh [2];
  logic lv [2], pl [2];

  task automatic model_step();
    int dig, idx;
    logic [31:0] sel;
    logic raw [2];
    logic s2;
    if (rst) begin
      ms = 0; n = 0; mc = '0; mw = '0; man = '1; mcat = 8'hFF;
      for (int b = 0; b < 2; b++) begin
        dl[b] = '0; sh[b] = '0; lv[b] = 1'b0; pl[b] = 1'b0;
      end
      return;
    end
    dig = (n / RD) % DG;
    man = ~(8'b1 << dig);
    mcat = HEX[4'(mw >> (4 * dig))] & ((dig == 0 && ms == 0) ? 8'h7F : 8'hFF);
    idx = int'(sw_sel);
    sel = (idx < NS) ? disp_data[idx*32 +: 32] : mc;
    n++;
    if (n % (RD * DG) == 0) mw = sel;
    if (ms != 0) mc = mc + 32'd1;
    ms = ms == 1 ? (pl[0] ? 0 : 1) : ms == 2 ? 0 : pl[0] ? 1 : pl[1] ? 2 : 0;
    raw[0] = btn_run;
    raw[1] = btn_step;
    // a level is accepted once the last DEB synchronised samples all disagree with it
    for (int b = 0; b < 2; b++) begin
      s2 = dl[b][1];
      dl[b] = {dl[b][0], raw[b]};
      sh[b] = {sh[b][DEB-2:0], s2};
      pl[b] = 1'b0;
      if (sh[b] == {DEB{~lv[b]}}) begin
        lv[b] = ~lv[b];
        pl[b] = lv[b];
      end
    end
  endtask

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    check("model", {cpu_ce, halted, ce_count, seg_an, seg_cat},
          {ms != 0, ms == 0, mc, man, mcat});
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
  endtask

  task automatic wait_ce(input string nm);
    int k = 0;
    while (cpu_ce !== 1'b1 && k < 30) begin
      tick();
      k++;
    end
    check(nm, cpu_ce, 1'b1);
  endtask

  typedef struct {
    logic [2:0] sel;
    logic [31:0] word;
    logic [63:0] cats;
  } vec_t;
  vec_t vt [4];

  initial begin
    logic [63:0] got, cats0;
    int cnt, idx;
    logic done;
    vt[0] = '{3'd2, 32'h12345678, 64'hF9A4B099_9282F880};
    vt[1] = '{3'd0, 32'h89ABCDEF, 64'h80908883_C6A1868E};
    vt[2] = '{3'd3, 32'h00000000, 64'hC0C0C0C0_C0C0C0C0};
    vt[3] = '{3'd1, 32'hF0E1D2C3, 64'h8EC086F9_A1A4C6B0};

    ticks(2);
    check("reset_ce", cpu_ce, 1'b0);
    check("reset_halted", halted, 1'b1);
    check("reset_count", ce_count, 32'd0);
    check("reset_seg", {seg_an, seg_cat}, 16'hFFFF);
    rst = 1'b0;
    tick();
    check("first_digit", {seg_an, seg_cat}, 16'hFE40);

    for (int v = 0; v < 4; v++) begin
      idx = int'(vt[v].sel);
      disp_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      disp_data[idx*32 +: 32] = vt[v].word;
      sw_sel = vt[v].sel;
      got = '0;
      for (int k = 0; k < 3 * RD * DG; k++) begin
        tick();
        for (int i = 0; i < DG; i++)
          if (seg_an == ~(8'b1 << i)) got[8*i +: 8] = seg_cat;
      end
      for (int i = 0; i < DG; i++)
        check($sformatf("scan v%0d d%0d", v, i), got[8*i +: 8],
              vt[v].cats[8*i +: 8] & (i == 0 ? 8'h7F : 8'hFF));
    end

    do_reset();
    btn_step = 1'b1;
    ticks(3);
    btn_step = 1'b0;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      cnt += int'(cpu_ce);
    end
    check("step_short", cnt, 0);
    btn_step = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 10) btn_step = 1'b0;
      tick();
      cnt += int'(cpu_ce);
    end
    check("step_ce_cycles", cnt, 1);
    check("step_count", ce_count, 32'd1);
    check("step_halted", halted, 1'b1);

    do_reset();
    btn_run = 1'b1;
    ticks(6);
    btn_run = 1'b0;
    wait_ce("run_enter");
    btn_step = 1'b1;
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (k == 8) btn_step = 1'b0;
      tick();
      cnt += int'(!cpu_ce);
    end
    check("step_in_run", cnt, 0);
    cnt = 0;
    while (ce_count != 32'd20 && cnt < 100) begin
      tick();
      cnt++;
    end
    check("run_count20", ce_count, 32'd20);
    btn_run = 1'b1;
    ticks(6);
    btn_run = 1'b0;
    ticks(10);
    check("run_halted", halted, 1'b1);
    check("run_final_count", ce_count, 32'd20 + DEB + 3);

    do_reset();
    btn_run = 1'b1;
    btn_step = 1'b1;
    ticks(6);
    btn_run = 1'b0;
    btn_step = 1'b0;
    wait_ce("both_enter");
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      cnt += int'(!cpu_ce);
    end
    check("both_no_step", cnt, 0);
    check("both_running", halted, 1'b0);

    do_reset();
    disp_data = '0;
    disp_data[2*32 +: 32] = vt[0].word;
    disp_data[0 +: 32] = vt[1].word;
    sw_sel = 3'd2;
    ticks(RD * DG + 1);
    cnt = 0;
    while (seg_an != ~8'h08 && cnt < 30) begin
      tick();
      cnt++;
    end
    check("mid_d3", {seg_an, seg_cat}, {~8'h08, 8'h92});
    sw_sel = 3'd0;
    cats0 = vt[0].cats;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      tick();
      for (int i = 1; i < DG; i++)
        if (seg_an == ~(8'b1 << i)) check($sformatf("mid_old d%0d", i), seg_cat, cats0[8*i +: 8]);
      if (seg_an == 8'hFE) begin
        check("mid_new d0", seg_cat, 8'h0E);
        done = 1'b1;
      end
    end
    check("mid_wrap_seen", done, 1'b1);

    do_reset();
    sw_sel = 3'd2;
    btn_run = 1'b1;
    ticks(6);
    btn_run = 1'b0;
    wait_ce("wrap_enter");
    ticks(3);
    force dut.ce_count = 32'hFFFFFFFF;
    mc = 32'hFFFFFFFF;
    #1;
    release dut.ce_count;
    tick();
    check("wrap_zero", ce_count, 32'd0);
    rst = 1'b1;
    tick();
    check("rst_run_ce", {cpu_ce, halted}, 2'b01);
    check("rst_run_seg", {seg_an, seg_cat}, 16'hFFFF);
    rst = 1'b0;
    tick();
    check("rst_run_digit0", {seg_an, seg_cat}, 16'hFE40);

    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 9) == 0) btn_run = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) btn_step = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 63) == 0) sw_sel = SW'($urandom_range(0, 7));
      if ($urandom_range(0, 127) == 0) disp_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
